// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, the slave FSM state type and the byte-lane mask helper.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_X8  = 3'd0,
    HSIZE_X16 = 3'd1,
    HSIZE_X32 = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ram_state_e;

  // Sizes above x32 fall into the full-word mask; misaligned x16/x32 use aligned lanes.
  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_X8:  byte_mask = 4'b0001 << addr;
      HSIZE_X16: byte_mask = addr[1] ? 4'b1100 : 4'b0011;
      default:   byte_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_ram_array.sv
// Single-port 2^ADDR_BITS x 32 RAM with per-byte write enables.
// Writes are clocked; the read is combinational from the same port address.
module ahb_lite_ram_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [3:0]           we,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_ram_slave.sv
// AHB-Lite block-RAM responder with WAIT_STATES wait cycles per beat.
// Define AHB_RAM_ERROR_EN to build the two-cycle ERROR path for illegal transfers.
module ahb_lite_ram_slave
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  ram_state_e           state;
  logic [3:0]           cnt;
  logic                 hready_q;
  logic                 dp_active;
  logic                 dp_write;
  logic [ADDR_BITS-1:0] dp_word;
  logic [3:0]           dp_mask;
  logic [31:0]          rdata_hold;
  logic [31:0]          ram_rdata;
  logic [3:0]           ram_we;
  logic                 accept;
  logic                 unused;

  assign accept = hready_q && HSEL && HTRANS[1];
  assign unused = ^{HBURST, HTRANS[0], HADDR};

`ifdef AHB_RAM_ERROR_EN
  logic hresp_q;
  logic illegal;
  assign illegal = (HSIZE > 3'd2)
                || ((HSIZE == HSIZE_X16) && HADDR[0])
                || ((HSIZE == HSIZE_X32) && (HADDR[1:0] != 2'b00))
                || ({1'b0, HADDR[31:2]} >= 31'(2**ADDR_BITS));
  assign HRESP = hresp_q;
`else
  assign HRESP = 1'b0;
`endif

  // The read is served from the data-phase address after any preceding write has
  // committed, so write-masked lanes of a back-to-back read already carry HWDATA.
  assign ram_we = (dp_active && dp_write && hready_q && !HRESET) ? dp_mask : 4'b0000;
  assign HRDATA = (dp_active && !dp_write) ? ram_rdata : rdata_hold;
  assign HREADY = hready_q;

  ahb_lite_ram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk   (HCLK),
    .addr  (dp_word),
    .we    (ram_we),
    .wdata (HWDATA),
    .rdata (ram_rdata)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hready_q   <= 1'b1;
      dp_active  <= 1'b0;
      rdata_hold <= '0;
`ifdef AHB_RAM_ERROR_EN
      hresp_q    <= 1'b0;
`endif
    end else begin
      if (hready_q && dp_active && !dp_write) rdata_hold <= ram_rdata;
      case (state)
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
          end
        end
`ifdef AHB_RAM_ERROR_EN
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
        end
`endif
        default: begin
          // Bus is ready here: the current data phase ends and a new one may begin.
          state     <= ST_IDLE;
          hready_q  <= 1'b1;
          dp_active <= 1'b0;
`ifdef AHB_RAM_ERROR_EN
          hresp_q   <= 1'b0;
`endif
          if (accept) begin
`ifdef AHB_RAM_ERROR_EN
            if (illegal) begin
              state    <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else
`endif
            begin
              dp_active <= 1'b1;
              dp_write  <= HWRITE;
              dp_word   <= HADDR[ADDR_BITS+1:2];
              dp_mask   <= byte_mask(HSIZE, HADDR[1:0]);
              if (WAIT_STATES > 0) begin
                state    <= ST_WAIT;
                cnt      <= 4'(WAIT_STATES);
                hready_q <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_ram_slave.sv
// Scoreboard bench: a zero-wait and a two-wait-state slave share one AHB-Lite bus.
module tb_ahb_lite_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel0, hsel2, use2;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic        hwrite;
  logic [31:0] rdata0, rdata2;
  logic        rdy0, rdy2, resp0, resp2;

  always #5 clk = ~clk;

  ahb_lite_ram_slave #(.ADDR_BITS(10), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HBURST(hburst), .HWRITE(hwrite), .HWDATA(hwdata),
    .HRDATA(rdata0), .HREADY(rdy0), .HRESP(resp0)
  );

  ahb_lite_ram_slave #(.ADDR_BITS(10), .WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HBURST(hburst), .HWRITE(hwrite), .HWDATA(hwdata),
    .HRDATA(rdata2), .HREADY(rdy2), .HRESP(resp2)
  );

  wire        bus_rdy   = use2 ? rdy2 : rdy0;
  wire        bus_resp  = use2 ? resp2 : resp0;
  wire [31:0] bus_rdata = use2 ? rdata2 : rdata0;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        resp;
    int          waits;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   in_dp = 1'b0;
  int   low   = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  // Monitor: tracks data phases on the bus and scores each completion.
  always @(negedge clk) begin
    if (rst) begin
      if (in_dp && q.size() > 0) void'(q.pop_front());
      in_dp = 1'b0;
      low   = 0;
    end else begin
      if (in_dp) begin
        if (q.size() == 0) begin
          check("no_expectation", 32'd1, 32'd0);
          in_dp = 1'b0;
        end else if (!bus_rdy) begin
          low++;
          check({q[0].name, "_lowresp"}, {31'd0, bus_resp}, {31'd0, q[0].resp});
        end else begin
          exp_t e;
          e = q.pop_front();
          check({e.name, "_resp"}, {31'd0, bus_resp}, {31'd0, e.resp});
          check({e.name, "_waits"}, 32'(low), 32'(e.waits));
          if (e.rd && !e.resp) check({e.name, "_data"}, bus_rdata, e.data);
          in_dp = 1'b0;
        end
      end
      if (bus_rdy && (hsel0 || hsel2) && htrans[1]) begin
        in_dp = 1'b1;
        low   = 0;
      end
    end
  end

  task automatic beat(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                      input logic [31:0] wd, input logic [31:0] xd, input logic xr,
                      input int xw, input string nm);
    exp_t e;
    bit   ok;
    e.rd = !wr; e.data = xd; e.resp = xr; e.waits = xw; e.name = nm;
    q.push_back(e);
    haddr = a; hsize = sz; hwrite = wr; htrans = 2'b10;
    hsel0 = !use2; hsel2 = use2;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus_rdy;
      @(posedge clk);
      #1;
    end
    if (!ok) check({nm, "_accept_timeout"}, 32'd0, 32'd1);
    hwdata = wd;
    htrans = 2'b00; hsel0 = 1'b0; hsel2 = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      #1;
      done = (q.size() == 0) && !in_dp;
    end
    if (!done) check({nm, "_drain_timeout"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; use2 = 1'b0; hsel0 = 1'b0; hsel2 = 1'b0;
    haddr = '0; hwdata = '0; htrans = 2'b00; hsize = 3'd2; hburst = 3'd0; hwrite = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_hrdata", rdata0, 32'h0);
    check("reset_hready", {31'd0, rdy0}, 32'd1);
    check("reset_hresp", {31'd0, resp0}, 32'd0);
    check("reset_hready_ws2", {31'd0, rdy2}, 32'd1);
    @(posedge clk); #1;

    // Zero-wait slave: word write/read, byte merge, back-to-back forwarding, lanes.
    beat(32'h10, 3'd2, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 0, "t1_wr");
    beat(32'h10, 3'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 0, "t1_rd");
    beat(32'h11, 3'd0, 1'b1, 32'h0000AA00, 32'h0,        1'b0, 0, "t2_wr");
    beat(32'h10, 3'd2, 1'b0, 32'h0,        32'hDEADAAEF, 1'b0, 0, "t2_rd");
    beat(32'h20, 3'd2, 1'b1, 32'h12345678, 32'h0,        1'b0, 0, "t3_wr");
    beat(32'h20, 3'd2, 1'b0, 32'h0,        32'h12345678, 1'b0, 0, "t3_fwd");
    beat(32'h22, 3'd1, 1'b1, 32'hBEEF0000, 32'h0,        1'b0, 0, "h16_wr");
    beat(32'h23, 3'd0, 1'b1, 32'h11000000, 32'h0,        1'b0, 0, "b8_wr");
    beat(32'h20, 3'd2, 1'b0, 32'h0,        32'h11EF5678, 1'b0, 0, "lanes_rd");
    beat(32'h24, 3'd2, 1'b1, 32'h55555555, 32'h0,        1'b0, 0, "hold_wr");
    drain("t3");
    @(negedge clk);
    check("hrdata_hold", rdata0, 32'h11EF5678);
    @(posedge clk); #1;

    beat(32'h0, 3'd2, 1'b1, 32'h0BADF00D, 32'h0, 1'b0, 0, "pre0_wr");
    beat(32'h4, 3'd2, 1'b1, 32'h00000004, 32'h0, 1'b0, 0, "pre4_wr");
`ifdef AHB_RAM_ERROR_EN
    beat(32'h0,    3'd3, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 1, "err_size");
    beat(32'h2,    3'd2, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 1, "err_misalign");
    beat(32'h1004, 3'd2, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 1, "err_range");
    beat(32'h0,    3'd2, 1'b0, 32'h0,        32'h0BADF00D, 1'b0, 0, "err_ram0");
    beat(32'h4,    3'd2, 1'b0, 32'h0,        32'h00000004, 1'b0, 0, "err_ram4");
`else
    beat(32'h0,    3'd3, 1'b1, 32'hCAFEF00D, 32'h0,        1'b0, 0, "sz3_wr");
    beat(32'h0,    3'd2, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0, 0, "sz3_rd");
    beat(32'h1004, 3'd2, 1'b1, 32'h1234ABCD, 32'h0,        1'b0, 0, "wrap_wr");
    beat(32'h4,    3'd2, 1'b0, 32'h0,        32'h1234ABCD, 1'b0, 0, "wrap_rd");
`endif
    drain("t4");

    // Two-wait-state slave: stretched beats, then reset during a waited write.
    use2 = 1'b1;
    beat(32'h40, 3'd2, 1'b1, 32'hA5A5A5A5, 32'h0,        1'b0, 2, "ws_wr");
    beat(32'h40, 3'd2, 1'b0, 32'h0,        32'hA5A5A5A5, 1'b0, 2, "ws_rd");
    beat(32'h30, 3'd2, 1'b1, 32'h00000000, 32'h0,        1'b0, 2, "ws30_wr");
    beat(32'h30, 3'd2, 1'b0, 32'h0,        32'h00000000, 1'b0, 2, "ws30_rd");
    drain("t5");

    beat(32'h30, 3'd2, 1'b1, 32'h77777777, 32'h0, 1'b0, 2, "rst_wr");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hready", {31'd0, rdy2}, 32'd1);
    check("rst_hresp", {31'd0, resp2}, 32'd0);
    check("rst_hrdata", rdata2, 32'h0);
    @(posedge clk); #1;
    beat(32'h30, 3'd2, 1'b0, 32'h0, 32'h00000000, 1'b0, 2, "rst_rd");
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
